// File: rtl/iso14443a_app_loopback_pkg.sv
// Shared types for the ISO 14443A application loopback responder.
package iso14443a_app_loopback_pkg;
  typedef logic [7:0] byte_t;
endpackage

// File: rtl/iso14443a_app_ifaces.sv
// Byte-stream interfaces between the ISO 14443A core and the application layer.
interface rx_interface;
  logic       soc;
  logic       eoc;
  logic [7:0] data;
  logic       data_valid;
  logic       error;
  modport in_byte  (input  soc, eoc, data, data_valid, error);
  modport out_byte (output soc, eoc, data, data_valid, error);
endinterface

interface tx_interface;
  logic [7:0] data;
  logic       data_valid;
  logic       last;
  logic       req;
  modport out_byte (output data, data_valid, last, input  req);
  modport in_byte  (input  data, data_valid, last, output req);
endinterface

// File: rtl/app_loopback_pingpong_buf.sv
// Two flop-based frame banks with lengths; writes fill the inactive bank,
// commit publishes it by flipping the active bank.
module app_loopback_pingpong_buf
  import iso14443a_app_loopback_pkg::*;
#(
  parameter  int BUF_BYTES = 32,
  localparam int AW        = (BUF_BYTES > 1) ? $clog2(BUF_BYTES) : 1,
  localparam int LW        = $clog2(BUF_BYTES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  byte_t         wr_data,
  input  logic          commit,
  input  logic [LW-1:0] commit_len,
  input  logic [AW-1:0] rd_addr,
  output byte_t         rd_data,
  output logic [LW-1:0] rd_len
);
  byte_t         mem [2][BUF_BYTES];
  logic [LW-1:0] len [2];
  logic          active;

  // Byte storage: not reset, contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[~active][wr_addr] <= wr_data;
  end

  // Commit stores the length of the write bank and makes it the active bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      len[0] <= '0;
      len[1] <= '0;
    end else if (commit) begin
      len[~active] <= commit_len;
      active       <= ~active;
    end
  end

  assign rd_data = mem[active][rd_addr];
  assign rd_len  = len[active];
endmodule

// File: rtl/iso14443a_app_loopback.sv
// Application loopback: captures each I-Block INF field and echoes it
// XOR-masked; replays the last committed reply on request.
module iso14443a_app_loopback
  import iso14443a_app_loopback_pkg::*;
#(
  parameter int    BUF_BYTES = 32,
  parameter byte_t XOR_MASK  = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  rx_interface.in_byte     app_rx_iface,
  tx_interface.out_byte    app_tx_iface,
  input  logic             app_resend_last,
  output logic             rx_overflow,
  output logic             busy
);
  localparam int            AW      = (BUF_BYTES > 1) ? $clog2(BUF_BYTES) : 1;
  localparam int            LW      = $clog2(BUF_BYTES + 1);
  localparam logic [LW-1:0] MAX_PTR = LW'(BUF_BYTES);
  localparam logic [LW-1:0] ONE     = LW'(1);

  typedef enum logic [1:0] {IDLE, RECEIVE, SEND} state_t;

  state_t        state, state_d;
  logic [LW-1:0] wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d, rd_len;
  logic          ovf_frame, ovf_frame_d, rx_overflow_d, have_reply, have_reply_d;
  logic          wr_en, commit, send, tx_last;
  byte_t         rd_data;

  app_loopback_pingpong_buf #(.BUF_BYTES(BUF_BYTES)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_ptr[AW-1:0]),
    .wr_data    (app_rx_iface.data),
    .commit     (commit),
    .commit_len (wr_ptr),
    .rd_addr    (rd_ptr[AW-1:0]),
    .rd_data    (rd_data),
    .rd_len     (rd_len)
  );

  assign send                    = (state == SEND);
  assign tx_last                 = send && (rd_ptr == rd_len - ONE);
  assign app_tx_iface.data_valid = send;
  assign app_tx_iface.last       = tx_last;
  assign app_tx_iface.data       = send ? (rd_data ^ XOR_MASK) : 8'h00;

  // Next-state and datapath control; eoc outranks soc and resend.
  always_comb begin
    state_d       = state;
    wr_ptr_d      = wr_ptr;
    rd_ptr_d      = rd_ptr;
    ovf_frame_d   = ovf_frame;
    rx_overflow_d = rx_overflow;
    have_reply_d  = have_reply;
    wr_en         = 1'b0;
    commit        = 1'b0;
    unique case (state)
      IDLE: begin
        if (app_rx_iface.soc) begin
          state_d     = RECEIVE;
          wr_ptr_d    = '0;
          ovf_frame_d = 1'b0;
        end else if (app_resend_last && have_reply) begin
          state_d  = SEND;
          rd_ptr_d = '0;
        end
      end
      RECEIVE: begin
        if (app_rx_iface.eoc) begin
          if (!app_rx_iface.error && !ovf_frame && wr_ptr != '0) begin
            commit       = 1'b1;
            have_reply_d = 1'b1;
            rd_ptr_d     = '0;
            state_d      = SEND;
          end else begin
            state_d = IDLE;
          end
        end else if (app_rx_iface.soc) begin
          wr_ptr_d    = '0;
          ovf_frame_d = 1'b0;
        end else if (app_rx_iface.data_valid) begin
          if (wr_ptr < MAX_PTR) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr + ONE;
          end else begin
            ovf_frame_d   = 1'b1;
            rx_overflow_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (app_rx_iface.soc) begin
          state_d     = RECEIVE;
          wr_ptr_d    = '0;
          ovf_frame_d = 1'b0;
        end else if (app_tx_iface.req) begin
          // Pointer parks on the last byte so the read address stays in range.
          if (tx_last) state_d  = IDLE;
          else         rd_ptr_d = rd_ptr + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and control registers; busy tracks the registered state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ovf_frame   <= 1'b0;
      rx_overflow <= 1'b0;
      have_reply  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      wr_ptr      <= wr_ptr_d;
      rd_ptr      <= rd_ptr_d;
      ovf_frame   <= ovf_frame_d;
      rx_overflow <= rx_overflow_d;
      have_reply  <= have_reply_d;
      busy        <= (state_d != IDLE);
    end
  end
endmodule

// File: doc/iso14443a_app_loopback.md
# iso14443a_app_loopback

Application-layer loopback responder sitting directly downstream of the ISO 14443A core on its application interfaces.

- Receives the INF field of each STD I-Block byte-by-byte and stores it in a ping-pong buffer.
- Replies with the same bytes, XOR-masked, once the frame ends.
- Replays the last committed reply on `app_resend_last`.
- Serves as the reference application for system bring-up and for the full-stack test bench.

## Interface

Parameters:
- `BUF_BYTES`, default 32: maximum INF length stored per frame; must be ≥ 1.
- `XOR_MASK`, default 8'h00: XOR'ed into every replied byte.

Ports:
- `clk`  in  1: 13.56 MHz recovered carrier clock, same clock as the core.
- `rst`  in  1: reset, asynchronous, active-high.
- `app_rx_iface`  rx_interface.in_byte  –: byte stream from the core.
  - Signals: `soc`, `eoc`, `data[7:0]`, `data_valid`, `error`.
  - Each is a 1-cycle pulse except `error`, which is qualified by `eoc`.
- `app_tx_iface`  tx_interface.out_byte  –: reply stream to the core.
  - Driven signals: `data[7:0]`, `data_valid`, `last`.
  - `req` is the input.
- `app_resend_last`  in  1: 1-cycle pulse from the core requesting a replay of the previous reply.
- `rx_overflow`  out  1: sticky flag; set when any frame exceeds `BUF_BYTES`.
- `busy`  out  1: high in any state other than IDLE.

## Operation

Buffer:
- Two banks of `BUF_BYTES` × 8 flops plus one length register per bank.
- Lengths are `$clog2(BUF_BYTES+1)` bits wide.
- `active` selects the committed bank; all writes go to bank `!active`.
- `have_reply` is cleared by reset and set on the first commit.

State machine:
- IDLE
  - `soc` → RECEIVE; write pointer cleared; `ovf_frame` cleared.
  - `app_resend_last` with `have_reply` → SEND from the active bank.
  - `app_resend_last` without `have_reply` → ignored.
- RECEIVE
  - Each `data_valid`: if the pointer is below `BUF_BYTES`, write the byte and increment; otherwise set `ovf_frame` and `rx_overflow`. The pointer saturates and never wraps.
  - `eoc` with `!error`, `!ovf_frame` and a non-zero pointer: commit. Set the write-bank length, toggle `active`, set `have_reply`, go to SEND.
  - `eoc` otherwise: discard, go to IDLE. `active` and the committed bank are untouched.
  - `soc`: restart the frame (pointer ← 0).
- SEND
  - Drive `data = buf[active][rd_ptr] ^ XOR_MASK` with `data_valid` = 1.
  - `last` = 1 when `rd_ptr == len[active]-1`.
  - Transfer occurs on a cycle with `data_valid && req`; `rd_ptr` increments.
  - Transfer with `last` → IDLE.
  - `soc` → abort: `data_valid` low next cycle, go to RECEIVE.
  - `app_resend_last` is ignored.

Simultaneous events:
- `eoc` and `app_resend_last` in the same cycle: `eoc` wins and the resend is dropped.
- `soc` and `eoc` in the same cycle: `eoc` is processed first and `soc` is ignored. The core never produces this.

Other rules:
- `data`, `last` and the buffer address are stable while `data_valid && !req`.
- Reset mid-operation:
  - All state, pointers, `active`, `have_reply` and `rx_overflow` clear.
  - Buffer contents are not reset; they are don't-care until written.

## Timing

- Reset values:
  - `data_valid` = 0, `last` = 0, `data` = 8'h00.
  - `busy` = 0, `rx_overflow` = 0.
  - State = IDLE.
- Buffer read is combinational from flops.
- Qualifying `eoc` in cycle N → `data_valid` = 1 with byte 0 in N+1.
- `app_resend_last` in cycle N (IDLE) → `data_valid` in N+1.
- Each `req` in cycle M → next byte presented in M+1. The final transfer drops `data_valid` in M+1.
- Maximum throughput is one byte per cycle while `req` is held high.
- `busy` is registered with the state.

## Structure

- The `State` enum stays local to the module.
- `BUF_BYTES`-derived widths are local parameters.
- No new package content. The rx/tx interfaces are the existing shared ones.
- One sub-module, `app_loopback_pingpong_buf`:
  - Contains both banks, both lengths and `active`.
  - Ports: `clk`, write enable/address/data, commit, `rd_addr`, `rd_data`, `rd_len`.
  - Flop-based.

## Test plan

- Frame 8'h01 8'h02 8'h03, no error, `XOR_MASK` = 8'hFF, `req` held high → reply 8'hFE 8'hFD 8'hFC, `last` on the third byte, first byte the cycle after `eoc`.
- Good frame 8'hAA 8'h55, then a frame with `error` at `eoc`, then `app_resend_last` → replay 8'hAA 8'h55; no reply follows the errored frame.
- 33 bytes with `BUF_BYTES` = 32 → no reply, `rx_overflow` = 1 until reset, previous reply still replayable.
- `req` gaps of 0, 1 and 5 cycles → `data`/`last` held stable during gaps, every byte transferred exactly once.
- `soc` during SEND after 1 of 4 bytes → `data_valid` low next cycle, new frame received and echoed; also `app_resend_last` after reset → no response, `busy` stays 0.
- `rst` pulsed mid-RECEIVE and mid-SEND → outputs return to reset values asynchronously, and `app_resend_last` is then ignored.
